// File: rtl/ones_gen_pkg.sv
// Shared types and helpers for the ones-pattern generator (controller/datapath split).
package ones_gen_pkg;

  localparam int W_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUILD = 2'd1,
    S_SEND  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Requests above the word width clamp to all ones.
  function automatic int unsigned sat_count(input int unsigned count, input int unsigned w);
    return (count > w) ? w : count;
  endfunction

endpackage

// File: rtl/ones_gen_datapath.sv
// Datapath for ones_pattern_gen: pattern register, ones counter and (with SERIAL_OUT_EN) serial shifter.
module ones_gen_datapath
  import ones_gen_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int CW = $clog2(W + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [CW-1:0] i_count,
  input  logic          i_load_cnt,
  input  logic          i_clr_pat,
  input  logic          i_shift_one,
`ifdef SERIAL_OUT_EN
  input  logic          i_load_ser,
  input  logic          i_shift_ser,
  output logic          o_bit_last,
  output logic          o_ser_bit,
`endif
  output logic          o_cnt_zero,
  output logic [W-1:0]  o_pattern
);

  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_pat;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_pat <= '0;
    end else begin
      if (i_load_cnt)
        r_cnt <= CW'(sat_count(32'(i_count), W));
      else if (i_shift_one)
        r_cnt <= r_cnt - 1'b1;

      if (i_clr_pat)
        r_pat <= '0;
      else if (i_shift_one)
        r_pat <= {r_pat[W-2:0], 1'b1};
    end
  end

  assign o_cnt_zero = (r_cnt == '0);
  assign o_pattern  = r_pat;

`ifdef SERIAL_OUT_EN
  localparam int IW = $clog2(W);

  logic [W-1:0]  r_ser;
  logic [IW-1:0] r_idx;

  // Snapshot of the finished word, shifted out LSB first.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_ser <= '0;
      r_idx <= '0;
    end else if (i_load_ser) begin
      r_ser <= r_pat;
      r_idx <= '0;
    end else if (i_shift_ser) begin
      r_ser <= {1'b0, r_ser[W-1:1]};
      r_idx <= r_idx + 1'b1;
    end
  end

  assign o_bit_last = (r_idx == IW'(W - 1));
  assign o_ser_bit  = r_ser[0];
`endif

endmodule

// File: rtl/ones_pattern_gen.sv
// Thermometer-pattern generator: builds 2^k-1 from count k under an s/done handshake.
// Optional serial readout of the finished word when SERIAL_OUT_EN is defined.
module ones_pattern_gen
  import ones_gen_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int CW = $clog2(W + 1)
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  input  logic          s,
  input  logic [CW-1:0] count,
  output logic [W-1:0]  pattern,
  output logic          done,
  output logic          busy,
  output logic          ser_out,
  output logic          ser_valid
);

  state_t r_state;
  logic   w_cnt_zero;
  logic   w_load_cnt, w_clr_pat, w_shift_one;

  assign w_load_cnt  = (r_state == S_IDLE);
  assign w_clr_pat   = (r_state == S_IDLE);
  assign w_shift_one = (r_state == S_BUILD) && !w_cnt_zero;

`ifdef SERIAL_OUT_EN
  logic w_load_ser, w_shift_ser, w_bit_last, w_ser_bit;

  assign w_load_ser  = (r_state == S_BUILD) && w_cnt_zero;
  assign w_shift_ser = (r_state == S_SEND);
  assign ser_valid   = (r_state == S_SEND);
  assign ser_out     = (r_state == S_SEND) && w_ser_bit;
  assign busy        = (r_state == S_BUILD) || (r_state == S_SEND);
`else
  assign ser_valid   = 1'b0;
  assign ser_out     = 1'b0;
  assign busy        = (r_state == S_BUILD);
`endif

  assign done = (r_state == S_DONE);

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (s) r_state <= S_BUILD;
`ifdef SERIAL_OUT_EN
        S_BUILD: if (w_cnt_zero) r_state <= S_SEND;
        S_SEND:  if (w_bit_last) r_state <= S_DONE;
`else
        S_BUILD: if (w_cnt_zero) r_state <= S_DONE;
`endif
        S_DONE:  if (!s) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  ones_gen_datapath #(
    .W  (W),
    .CW (CW)
  ) u_dp (
    .i_clk       (CLOCK_50),
    .i_rst_n     (reset),
    .i_count     (count),
    .i_load_cnt  (w_load_cnt),
    .i_clr_pat   (w_clr_pat),
    .i_shift_one (w_shift_one),
`ifdef SERIAL_OUT_EN
    .i_load_ser  (w_load_ser),
    .i_shift_ser (w_shift_ser),
    .o_bit_last  (w_bit_last),
    .o_ser_bit   (w_ser_bit),
`endif
    .o_cnt_zero  (w_cnt_zero),
    .o_pattern   (pattern)
  );

endmodule

// File: tb/tb_ones_pattern_gen.sv
// Self-checking bench for ones_pattern_gen: operation-level model plus directed literal checks.
module tb_ones_pattern_gen;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);
`ifdef SERIAL_OUT_EN
  localparam int SER = W;
`else
  localparam int SER = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          s = 1'b0;
  logic [CW-1:0] count = '0;
  logic [W-1:0]  pattern;
  logic          done, busy, ser_out, ser_valid;

  int n_vec = 0;
  int n_err = 0;

  ones_pattern_gen #(.W(W), .CW(CW)) dut (
    .CLOCK_50  (clk),
    .reset     (rst),
    .s         (s),
    .count     (count),
    .pattern   (pattern),
    .done      (done),
    .busy      (busy),
    .ser_out   (ser_out),
    .ser_valid (ser_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ones(input int n);
    logic [63:0] t;
    t = (64'd1 << n) - 64'd1;
    return t[W-1:0];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Operation-level model: m_n = edges elapsed since the start edge.
  bit          m_act = 1'b0;
  int          m_k = 0;
  int          m_n = 0;
  logic [W-1:0] m_pat = '0;

  always @(posedge clk) begin
    if (!rst) begin
      m_act = 1'b0; m_pat = '0; m_n = 0; m_k = 0;
    end else if (!m_act) begin
      m_pat = '0;
      if (s) begin
        m_act = 1'b1; m_n = 0;
        m_k = (int'(count) > W) ? W : int'(count);
      end
    end else if (m_n >= m_k + 1 + SER && !s) begin
      m_act = 1'b0;
    end else begin
      if (m_n < m_k + 1 + SER) m_n++;
      m_pat = ones((m_n < m_k) ? m_n : m_k);
    end
  end

  always @(negedge clk) begin
    logic e_busy, e_done, e_sv, e_so;
    e_busy = m_act && (m_n <= m_k + SER);
    e_done = m_act && (m_n >= m_k + 1 + SER);
    e_sv   = (SER > 0) && m_act && (m_n >= m_k + 1) && (m_n <= m_k + SER);
    e_so   = e_sv && ((m_n - m_k - 1) < m_k);
    chk("model_pattern", 64'(pattern), 64'(m_pat));
    chk("model_done", 64'(done), 64'(e_done));
    chk("model_busy", 64'(busy), 64'(e_busy));
    chk("model_ser_valid", 64'(ser_valid), 64'(e_sv));
    chk("model_ser_out", 64'(ser_out), 64'(e_so));
  end

  // Waits for done with a cycle budget; counts edges (start edge included), busy and serial cycles.
  task automatic wait_done(input int edges0, output int edges, output int busyc,
                           output int svc, output logic [63:0] bits);
    edges = edges0; busyc = 0; svc = 0; bits = '0;
    while (1) begin
      @(negedge clk);
      edges++;
      if (busy) busyc++;
      if (ser_valid) begin
        if (svc < 64) bits[svc] = ser_out;
        svc++;
      end
      if (done) break;
      if (edges > 200) begin
        chk("done_timeout", 64'(done), 64'd1);
        break;
      end
    end
  endtask

  task automatic run_op(input int c, output int edges, output int busyc,
                        output int svc, output logic [63:0] bits);
    count = CW'(c); s = 1'b1;
    wait_done(0, edges, busyc, svc, bits);
  endtask

  task automatic end_op();
    s = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("idle_pattern_cleared", 64'(pattern), 64'd0);
  endtask

  initial begin
    int e, b, sv;
    logic [63:0] bits;

    repeat (3) @(negedge clk);
    chk("reset_pattern", 64'(pattern), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // count=3: thermometer growth then handshake release
    count = CW'(3); s = 1'b1;
    @(negedge clk); chk("t1_e0_busy", 64'(busy), 64'd1);
    @(negedge clk); chk("t1_p1", 64'(pattern), 64'h01);
    @(negedge clk); chk("t1_p2", 64'(pattern), 64'h03);
    @(negedge clk); chk("t1_p3", 64'(pattern), 64'h07);
    wait_done(4, e, b, sv, bits);
    chk("t1_done_edges", 64'(e), 64'(5 + SER));
    chk("t1_done_pattern", 64'(pattern), 64'h07);
    @(negedge clk); chk("t1_done_held", 64'(done), 64'd1);
    s = 1'b0;
    @(negedge clk);
    chk("t1_done_drop", 64'(done), 64'd0);
    chk("t1_pattern_hold", 64'(pattern), 64'h07);
    @(negedge clk); chk("t1_pattern_clear", 64'(pattern), 64'h00);

    run_op(0, e, b, sv, bits);
    chk("t2_edges", 64'(e), 64'(2 + SER));
    chk("t2_busy", 64'(b), 64'(1 + SER));
    chk("t2_pattern", 64'(pattern), 64'h00);
    end_op();

    run_op(8, e, b, sv, bits);
    chk("t3_full", 64'(pattern), 64'hFF);
    end_op();
    run_op(12, e, b, sv, bits);
    chk("t3_sat", 64'(pattern), 64'hFF);
    chk("t3_sat_busy", 64'(b), 64'(9 + SER));
    end_op();

    // inputs changed mid-build are ignored
    count = CW'(6); s = 1'b1;
    @(negedge clk); @(negedge clk);
    count = CW'(1); s = 1'b0;
    wait_done(2, e, b, sv, bits);
    chk("t4_pattern", 64'(pattern), 64'h3F);
    @(negedge clk); @(negedge clk);

    count = CW'(5); s = 1'b1;
    @(negedge clk); @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_pattern", 64'(pattern), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_done", 64'(done), 64'd0);
    rst = 1'b1; s = 1'b0;
    @(negedge clk);
    run_op(2, e, b, sv, bits);
    chk("t5_restart", 64'(pattern), 64'h03);
    chk("t6_ser_cycles", 64'(sv), 64'(SER));
    chk("t6_ser_bits", 64'(bits), (SER > 0) ? 64'h03 : 64'h00);
    end_op();

    // randomized traffic checked only against the model
    for (int i = 0; i < 600; i++) begin
      count = CW'($urandom_range(0, (1 << CW) - 1));
      s     = ($urandom_range(0, 3) != 0);
      rst   = ($urandom_range(0, 49) != 0);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ones_pattern_gen.md
Name: ones_pattern_gen

Overview:
Inverse of the team's ones-counter. It takes a population count k and builds a W-bit word containing exactly k ones, right-justified in thermometer form (2^k - 1).
- Uses the same controller/datapath split and the same level-sensitive start/done handshake (s high to run, done held until s drops).
- Sits beside the counter on the DE1_SoC top. count comes from SW and pattern drives LEDR, so round-trip checks (count -> pattern -> counter) can be done on the board.

Parameters:
- W, 8, pattern width in bits (W >= 2).
- CW, $clog2(W+1), count input width.

Ports:
- CLOCK_50  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-low reset. Sampled on rising CLOCK_50; 0 = reset.
- s  input  1  start level. Run while 1; return to idle when 0 after done.
- count  input  CW  requested number of ones. Sampled only in IDLE.
- pattern  output  W  generated word.
- done  output  1  high while in DONE.
- busy  output  1  high in BUILD (and SEND when compiled in).
- ser_out  output  1  serial data bit (0 unless SERIAL_OUT_EN).
- ser_valid  output  1  ser_out qualifier (0 unless SERIAL_OUT_EN).

Behaviour:
- Reset (reset==0 at an edge), from any state, including mid-BUILD or mid-SEND:
  - state=IDLE, pattern=0, cnt=0, done=0, busy=0, ser_out=0, ser_valid=0.
- Internal cnt register, CW bits. Saturating load: cnt = (count > W) ? W : count.
- IDLE:
  - Each cycle: pattern <= 0; cnt <= sat(count).
  - s==1 -> BUILD, else stay. The count value loaded is the one present on the same edge that samples s==1.
- BUILD (busy=1):
  - cnt != 0: pattern <= {pattern[W-2:0], 1'b1}; cnt <= cnt-1; stay.
  - cnt == 0: -> DONE (SEND when compiled in). No shift on this cycle.
  - count and s are ignored. s dropping during BUILD does not abort.
- DONE (done=1):
  - pattern holds.
  - s==1: stay. s==0: -> IDLE. pattern reads 0 one cycle after entering IDLE.
- Latency: with edge E0 sampling s==1 in IDLE, done is first high after edge E0+k+1, i.e. k+2 edges into the operation counting E0. k=0 gives done after 2 edges with pattern=0.
- Boundaries:
  - k=W gives all ones.
  - count > W saturates to W.
  - No wrap; cnt never decrements below 0.
- Outputs done/busy are decoded from state (Moore). pattern is registered.
- Illegal state encoding -> IDLE on next edge.

Optional Feature:
- Macro SERIAL_OUT_EN.
- Defined:
  - Extra state SEND between BUILD and DONE.
  - On BUILD exit, the final pattern is copied into a shift register and a bit index is cleared.
  - In SEND, ser_valid=1 for exactly W consecutive cycles; ser_out is the pattern, LSB first.
  - After the W-th bit -> DONE; done latency grows by W cycles.
  - pattern holds its final value throughout SEND.
- Undefined: SEND, shift register and index are absent; ser_out and ser_valid are tied 0.

Decomposition:
- Package ones_gen_pkg holds:
  - state enum {S_IDLE, S_BUILD, S_SEND, S_DONE}, 2 bits;
  - default W;
  - function sat_count(count, W).
- One sub-module, ones_gen_datapath, holding pattern, cnt and the serial shifter.
  - Control inputs: load_cnt, clr_pat, shift_one, load_ser, shift_ser.
  - Status output: cnt_zero, plus bit_last when compiled in.
- The FSM stays in ones_pattern_gen, matching the team's controller/datapath partitioning.

Test Plan:
1. W=8, count=3, s=1 held:
   - pattern 8'h01, 8'h03, 8'h07 on successive BUILD cycles;
   - done=1 at edge E0+4 with pattern=8'h07, held while s=1;
   - s=0 -> done=0 next edge, pattern=8'h00 one edge later.
2. count=0, s=1 -> busy for 1 cycle, done after 2 edges, pattern=8'h00.
3. count=8 -> pattern=8'hFF; count=12 (saturate) -> pattern=8'hFF, 8 BUILD shifts.
4. count=6, s=1; after 2 BUILD cycles change count=1 and drop s -> build continues, done with pattern=8'h3F.
5. count=5, reset driven 0 on the 3rd BUILD cycle -> next edge pattern=0, busy=0, done=0, state IDLE; a restart with count=2 gives 8'h03.
6. SERIAL_OUT_EN, count=2:
   - ser_valid high for 8 cycles with ser_out = 1,1,0,0,0,0,0,0;
   - done rises on the edge after the last bit.
